// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: data width default, opcode
// encodings understood by the downstream ALU, and the issue FSM states.
package alu_pkg;

   localparam int ALU_WIDTH = 4;
   localparam int ALU_SEL_W = 3;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   // Highest legal opcode; anything above it is reported as illegal.
   localparam logic [2:0] OP_LAST = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the combinational ALU. Registers one command onto
// the ALU inputs, captures the ALU result one cycle later, keeps a running
// accumulator and offers the result downstream.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload stable until that edge;
// ready may be raised or lowered at any time and is never a function of the
// producer's own valid. Here cmd_ready depends combinationally on res_ready,
// so a finished result and the next command can swap on the same edge.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int SEL_W = ALU_SEL_W,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [SEL_W-1:0] cmd_sel,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_use_acc,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [SEL_W-1:0] alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             res_illegal,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count,
   output logic [1:0]       dbg_state_o
);

   issue_state_t     state_q, state_d;
   logic             cmd_ready_c;
   logic             accept;
   logic             exec_done;
   logic             res_taken;
   logic             sel_illegal;

   logic [WIDTH-1:0] alu_a_q, alu_b_q;
   logic [SEL_W-1:0] alu_sel_q;
   logic             res_valid_q, res_zero_q, res_illegal_q;
   logic [WIDTH-1:0] res_data_q;
   logic [WIDTH-1:0] acc_q;
   logic [CNT_W-1:0] op_count_q;

   assign accept      = cmd_valid && cmd_ready_c;
   assign exec_done   = (state_q == ST_EXEC);
   assign res_taken   = (state_q == ST_DONE) && res_ready;
   assign sel_illegal = (alu_sel_q > SEL_W'(OP_LAST));

   // Next-state and command-ready decode for the issue FSM.
   always_comb begin
      state_d     = state_q;
      cmd_ready_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready_c = 1'b1;
            if (cmd_valid) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (res_ready) begin
               cmd_ready_c = 1'b1;
               state_d     = cmd_valid ? ST_EXEC : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Operand/opcode registers: loaded only on an accepted command, held otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= '0;
      end else if (accept) begin
         alu_a_q   <= cmd_use_acc ? acc_q : cmd_a;
         alu_b_q   <= cmd_b;
         alu_sel_q <= cmd_sel;
      end
   end

   // Result capture at the end of EXEC; valid drops once downstream takes it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_zero_q    <= 1'b0;
         res_illegal_q <= 1'b0;
      end else if (exec_done) begin
         res_valid_q   <= 1'b1;
         res_data_q    <= alu_result;
         res_zero_q    <= (alu_result == '0);
         res_illegal_q <= sel_illegal;
      end else if (res_taken) begin
         res_valid_q   <= 1'b0;
      end
   end

   // Accumulator follows legal results as soon as they are produced, so a
   // command accepted while the result is still in DONE already chains on it.
   always_ff @(posedge clk) begin
      if (!rst_n)                        acc_q <= '0;
      else if (exec_done && !sel_illegal) acc_q <= alu_result;
   end

   // Count of results handed downstream; wraps naturally.
   always_ff @(posedge clk) begin
      if (!rst_n)         op_count_q <= '0;
      else if (res_taken) op_count_q <= op_count_q + CNT_W'(1);
   end

   assign cmd_ready   = cmd_ready_c;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_sel     = alu_sel_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_zero    = res_zero_q;
   assign res_illegal = res_illegal_q;
   assign acc         = acc_q;
   assign op_count    = op_count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural 4-bit ALU attached.
module tb_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_use_acc;
   logic [2:0] cmd_sel;
   logic [3:0] cmd_a, cmd_b;
   logic [3:0] alu_a, alu_b, alu_result;
   logic [2:0] alu_sel;
   logic       res_valid, res_ready, res_zero, res_illegal;
   logic [3:0] res_data, acc;
   logic [7:0] op_count;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   alu_issue_ctrl #(.WIDTH(4), .SEL_W(3), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_zero(res_zero), .res_illegal(res_illegal),
      .acc(acc), .op_count(op_count), .dbg_state_o(dbg_state)
   );

   function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] sel);
      case (sel)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         default: return 4'h0;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_a, alu_b, alu_sel);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // in_flight: a command was taken and its result appears after one edge.
   // pending: a result is being offered downstream.
   logic       m_init = 1'b0;
   logic       in_flight, pending;
   logic [3:0] m_a, m_b, m_acc, m_data;
   logic [2:0] m_sel;
   logic       m_zero, m_ill;
   logic [7:0] m_cnt;
   logic [3:0] exp_q[$];

   always @(posedge clk) begin
      logic take, give;
      logic [3:0] r;
      if (!rst_n) begin
         m_init = 1'b1; in_flight = 1'b0; pending = 1'b0;
         m_a = 0; m_b = 0; m_sel = 0; m_acc = 0; m_data = 0;
         m_zero = 0; m_ill = 0; m_cnt = 0;
         exp_q.delete();
      end else if (m_init) begin
         take = cmd_valid && !in_flight && (!pending || res_ready);
         give = pending && res_ready;
         if (give) begin
            m_cnt = m_cnt + 8'd1;
            pending = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (in_flight) begin
            r = alu_fn(m_a, m_b, m_sel);
            m_data = r; m_zero = (r == 4'h0); m_ill = (m_sel > 3'd4);
            if (!m_ill) m_acc = r;
            pending = 1'b1; in_flight = 1'b0;
            exp_q.push_back(r);
         end
         if (take) begin
            m_a = cmd_use_acc ? m_acc : cmd_a;
            m_b = cmd_b; m_sel = cmd_sel;
            in_flight = 1'b1;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (m_init) begin
         check("cmd_ready", cmd_ready, !in_flight && (!pending || res_ready));
         check("res_valid", res_valid, pending);
         check("alu_a", alu_a, m_a);
         check("alu_b", alu_b, m_b);
         check("alu_sel", alu_sel, m_sel);
         check("acc", acc, m_acc);
         check("op_count", op_count, m_cnt);
         if (pending) begin
            check("res_data", res_data, m_data);
            check("res_zero", res_zero, m_zero);
            check("res_illegal", res_illegal, m_ill);
         end
         if (res_valid && res_ready && exp_q.size() > 0)
            check("sb_result", res_data, exp_q[0]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cmd_ready && n < 20) begin tick(); n++; end
      if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic drive_cmd(input logic [2:0] sel, input logic [3:0] a,
                            input logic [3:0] b, input logic ua);
      cmd_sel = sel; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
   endtask

   task automatic run_op(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b,
                         input logic ua, input logic [3:0] e_data, input logic e_zero,
                         input logic e_ill, input logic [3:0] e_acc);
      res_ready = 1'b0;
      drive_cmd(sel, a, b, ua);
      wait_ready();
      tick();
      cmd_valid = 1'b0;
      check("exec_no_valid", res_valid, 1'b0);
      tick();
      check("op_valid", res_valid, 1'b1);
      check("op_data", res_data, e_data);
      check("op_zero", res_zero, e_zero);
      check("op_illegal", res_illegal, e_ill);
      check("op_acc", acc, e_acc);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("op_drained", res_valid, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n_acc, cyc;
      logic take_now;
      rst_n = 1'b0; res_ready = 1'b0;
      drive_cmd(3'b001, 4'h5, 4'h3, 1'b0);
      tick(); tick();
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_acc", acc, 4'h0);
      check("rst_op_count", op_count, 8'd0);
      check("rst_alu_sel", alu_sel, 3'b000);
      rst_n = 1'b1; cmd_valid = 1'b0;
      tick();

      // single add
      run_op(3'b000, 4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b0, 4'h8);
      check("add_count", op_count, 8'd1);

      // accumulator chain
      run_op(3'b001, 4'h2, 4'h2, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
      run_op(3'b011, 4'h9, 4'hF, 1'b1, 4'hF, 1'b0, 1'b0, 4'hF);
      run_op(3'b000, 4'h9, 4'h1, 1'b1, 4'h0, 1'b1, 1'b0, 4'h0);

      // illegal opcode leaves acc alone
      run_op(3'b000, 4'h2, 4'h4, 1'b0, 4'h6, 1'b0, 1'b0, 4'h6);
      run_op(3'b110, 4'h1, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 4'h6);
      check("ill_count", op_count, 8'd6);

      // backpressure with a second command waiting
      res_ready = 1'b0;
      drive_cmd(3'b000, 4'h1, 4'h1, 1'b0);
      wait_ready();
      tick();
      cmd_valid = 1'b0;
      tick();
      drive_cmd(3'b100, 4'h3, 4'h5, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("bp_cmd_ready", cmd_ready, 1'b0);
         check("bp_res_data", res_data, 4'h2);
         check("bp_res_valid", res_valid, 1'b1);
         tick();
      end
      res_ready = 1'b1;
      #1;
      check("bp_ready_follows", cmd_ready, 1'b1);
      tick();
      res_ready = 1'b0; cmd_valid = 1'b0;
      check("bp_count", op_count, 8'd7);
      check("bp_valid_low", res_valid, 1'b0);
      tick();
      check("bp_second_data", res_data, 4'h6);
      check("bp_second_acc", acc, 4'h6);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("bp_count2", op_count, 8'd8);

      // reset during EXEC
      drive_cmd(3'b000, 4'h1, 4'h2, 1'b0);
      wait_ready();
      tick();
      cmd_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_valid", res_valid, 1'b0);
      check("mid_rst_acc", acc, 4'h0);
      check("mid_rst_count", op_count, 8'd0);
      check("mid_rst_idle", cmd_ready, 1'b1);
      tick(); tick();
      check("mid_rst_no_result", res_valid, 1'b0);

      // back-to-back stream, op_count wraps past 255
      res_ready = 1'b1;
      drive_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      n_acc = 0; cyc = 0;
      while (n_acc < 260 && cyc < 2000) begin
         take_now = cmd_ready;
         tick();
         cyc++;
         if (take_now) begin
            n_acc++;
            drive_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         end
      end
      cmd_valid = 1'b0;
      check("stream_accepts", n_acc, 260);
      check("stream_cycles", cyc, 519);
      tick(); tick(); tick();
      check("wrap_count", op_count, 8'd4);
      check("stream_idle", res_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
